// File: rtl/fetch_queue.sv
// Instruction fetch front end: requests sequential words from instruction memory
// and buffers them in a small FIFO for decode, with redirect flush and wrap-around.
module fetch_queue #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc_next,
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic {
      ST_FETCH = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  occ_q, occ_d;
   logic              push_c;
   logic              pop_c;

   logic [DATA_W-1:0] mem_data_q [DEPTH];
   logic [ADDR_W-1:0] mem_pc_q   [DEPTH];

   assign imem_req      = (state_q == ST_FETCH) && !rst && !redirect;
   assign imem_addr     = fetch_pc_q;
   assign instr_valid   = (occ_q != '0) && !rst;
   assign instr         = mem_data_q[rd_ptr_q];
   assign instr_pc_next = mem_pc_q[rd_ptr_q];
   assign occupancy     = occ_q;

   assign push_c = imem_req && imem_ack;
   assign pop_c  = instr_valid && instr_ready && !redirect;

   // Next-state: redirect flushes everything; otherwise push/pop update the FIFO.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;
      if (redirect) begin
         fetch_pc_d = redirect_addr & ~ADDR_W'(3);
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         occ_d      = '0;
         state_d    = ST_FETCH;
      end else begin
         if (push_c) begin
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
         end
         if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         occ_d = occ_q + CNT_W'(push_c) - CNT_W'(pop_c);
         case (state_q)
            ST_FETCH: if (occ_d == CNT_W'(DEPTH)) state_d = ST_FULL;
            ST_FULL:  if (occ_d <  CNT_W'(DEPTH)) state_d = ST_FETCH;
            default:  state_d = ST_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_FETCH;
         fetch_pc_q <= RESET_PC;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
      end
   end

   // Entry storage is data-path only and carries no reset.
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_data_q[wr_ptr_q] <= imem_rdata;
         mem_pc_q[wr_ptr_q]   <= fetch_pc_q + ADDR_W'(4);
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue, checked every cycle against a
// queue-based reference model of the fetch/buffer behaviour.
module tb_fetch_queue;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 4;

   logic              clk;
   logic              rst;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_rdata;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_addr;
   logic              instr_valid;
   logic              instr_ready;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] instr_pc_next;
   logic [2:0]        occupancy;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [31:0] qd[$];
   logic [31:0] qp[$];
   logic [31:0] m_pc;
   logic        exp_req;

   fetch_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_addr(redirect_addr),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .instr_pc_next(instr_pc_next),
      .occupancy(occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply inputs at the falling edge, then compare outputs with the model.
   task automatic drive(input logic r, input logic rd, input logic [31:0] ra,
                        input logic ack, input logic rdy);
      logic exp_v;
      @(negedge clk);
      rst = r; redirect = rd; redirect_addr = ra; imem_ack = ack; instr_ready = rdy;
      imem_rdata = mem_word(imem_addr);
      #1;
      exp_req = !rst && !redirect && (qd.size() < DEPTH);
      exp_v   = !rst && (qd.size() != 0);
      chk("imem_req", 64'(imem_req), 64'(exp_req));
      if (exp_req) chk("imem_addr", 64'(imem_addr), 64'(m_pc));
      chk("occupancy", 64'(occupancy), 64'(qd.size()));
      chk("instr_valid", 64'(instr_valid), 64'(exp_v));
      if (exp_v) begin
         chk("instr", 64'(instr), 64'(qd[0]));
         chk("instr_pc_next", 64'(instr_pc_next), 64'(qp[0]));
      end
   endtask

   // Advance the model by one cycle using the inputs currently applied.
   task automatic adv();
      if (rst) begin
         qd.delete(); qp.delete(); m_pc = 32'h0;
      end else if (redirect) begin
         qd.delete(); qp.delete(); m_pc = redirect_addr & 32'hFFFF_FFFC;
      end else begin
         if (qd.size() != 0 && instr_ready) begin
            void'(qd.pop_front()); void'(qp.pop_front());
         end
         if (exp_req && imem_ack) begin
            qd.push_back(mem_word(m_pc));
            qp.push_back(m_pc + 32'd4);
            m_pc = m_pc + 32'd4;
         end
      end
      @(posedge clk);
   endtask

   task automatic cyc(input logic r, input logic rd, input logic [31:0] ra,
                      input logic ack, input logic rdy);
      drive(r, rd, ra, ack, rdy);
      adv();
   endtask

   initial begin
      rst = 1'b1; redirect = 1'b0; redirect_addr = '0; imem_ack = 1'b0;
      instr_ready = 1'b0; imem_rdata = '0; m_pc = 32'h0; exp_req = 1'b0;
      repeat (2) @(posedge clk);
      cyc(1, 0, 0, 1, 1);

      // Zero-wait streaming from reset
      drive(0, 0, 0, 1, 1);
      chk("rst_first_req", 64'(imem_req), 64'd1);
      chk("rst_first_addr", 64'(imem_addr), 64'h0);
      adv();
      drive(0, 0, 0, 1, 1);
      chk("stream_pc0", 64'(instr_pc_next), 64'd4);
      adv();
      drive(0, 0, 0, 1, 1);
      chk("stream_pc1", 64'(instr_pc_next), 64'd8);
      adv();
      drive(0, 0, 0, 1, 1);
      chk("stream_pc2", 64'(instr_pc_next), 64'd12);
      adv();

      // Backpressure from a fresh reset
      cyc(1, 0, 0, 0, 0);
      repeat (4) cyc(0, 0, 0, 1, 0);
      drive(0, 0, 0, 1, 0);
      chk("bp_occ", 64'(occupancy), 64'd4);
      chk("bp_req", 64'(imem_req), 64'd0);
      chk("bp_addr", 64'(imem_addr), 64'h10);
      adv();
      cyc(0, 0, 0, 1, 1);
      drive(0, 0, 0, 0, 0);
      chk("bp_req_again", 64'(imem_req), 64'd1);
      chk("bp_occ3", 64'(occupancy), 64'd3);
      adv();

      // Wait states: ack every third cycle
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) cyc(0, 0, 0, (i % 3) == 2, 0);
      drive(0, 0, 0, 0, 0);
      chk("ws_occ", 64'(occupancy), 64'd3);
      chk("ws_head", 64'(instr), 64'(mem_word(32'h0)));
      adv();

      // Redirect with coincident ack and pop
      drive(0, 1, 32'h103, 1, 1);
      adv();
      drive(0, 0, 0, 1, 1);
      chk("rd_occ", 64'(occupancy), 64'd0);
      chk("rd_valid", 64'(instr_valid), 64'd0);
      chk("rd_addr", 64'(imem_addr), 64'h100);
      adv();
      drive(0, 0, 0, 0, 0);
      chk("rd_pc_next", 64'(instr_pc_next), 64'h104);
      adv();

      // Address wrap-around
      cyc(0, 1, 32'hFFFF_FFFC, 0, 0);
      drive(0, 0, 0, 1, 0);
      chk("wrap_addr0", 64'(imem_addr), 64'hFFFF_FFFC);
      adv();
      drive(0, 0, 0, 0, 0);
      chk("wrap_pc_next", 64'(instr_pc_next), 64'h0);
      chk("wrap_addr1", 64'(imem_addr), 64'h0);
      adv();

      // Reset mid-stream with three entries queued
      cyc(0, 1, 32'h200, 0, 0);
      repeat (3) cyc(0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0);
      chk("mr_occ3", 64'(occupancy), 64'd3);
      adv();
      cyc(1, 0, 0, 1, 1);
      drive(1, 0, 0, 1, 1);
      chk("mr_occ0", 64'(occupancy), 64'd0);
      chk("mr_valid", 64'(instr_valid), 64'd0);
      chk("mr_req", 64'(imem_req), 64'd0);
      adv();
      drive(0, 0, 0, 0, 0);
      chk("mr_restart", 64'(imem_addr), 64'h0);
      adv();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic r_rst, r_rd, r_ack, r_rdy;
         logic [31:0] r_ra;
         r_rst = ($urandom_range(0, 199) == 0);
         r_rd  = ($urandom_range(0, 29) == 0);
         r_ra  = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : 32'h0) | $urandom_range(0, 4095);
         r_ack = ($urandom_range(0, 99) < 55);
         r_rdy = ($urandom_range(0, 99) < 60);
         cyc(r_rst, r_rd, r_ra, r_ack, r_rdy);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
